// File: rtl/dsp_mac_seq_if.sv
// Job, operand-read and DSP48A1 control bundle for dsp_mac_seq.
// The abort input exists only when DSP_MAC_SEQ_ABORT_EN is defined.
interface dsp_mac_seq_if #(
    parameter int LEN_W = 8,
    parameter int P_W   = 48
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             b_cascade;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [LEN_W-1:0] rd_addr;
    logic [7:0]       opmode;
    logic             ce;
    logic             rstp;
    logic             b_sel;
    logic [P_W-1:0]   p_in;
    logic [P_W-1:0]   result;
`ifdef DSP_MAC_SEQ_ABORT_EN
    logic             abort;
`endif

    modport slave (
`ifdef DSP_MAC_SEQ_ABORT_EN
        input  abort,
`endif
        input  start, len, b_cascade, p_in,
        output busy, done, rd_en, rd_addr, opmode, ce, rstp, b_sel, result
    );

    modport master (
`ifdef DSP_MAC_SEQ_ABORT_EN
        output abort,
`endif
        output start, len, b_cascade, p_in,
        input  busy, done, rd_en, rd_addr, opmode, ce, rstp, b_sel, result
    );
endinterface

// File: rtl/dsp_mac_seq.sv
// N-beat multiply-accumulate sequencer for one DSP48A1 slice; optional abort via DSP_MAC_SEQ_ABORT_EN.
// state | meaning
// IDLE  | waiting for start
// CLEAR | reset slice P register
// ISSUE | one operand read per cycle, addr 0..len-1
// DRAIN | let the slice pipeline empty, capture P on the last cycle
// DONE  | one-cycle done pulse
module dsp_mac_seq #(
    parameter int LEN_W   = 8,
    parameter int OPM_DLY = 2,
    parameter int P_LAT   = 1,
    parameter int P_W     = 48
) (
    input logic         clk,
    input logic         rst,
    dsp_mac_seq_if.slave bus
);
    localparam int DRAIN_N = OPM_DLY + P_LAT;
    localparam int CNT_W   = $clog2(DRAIN_N) + 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               bcas_q, bcas_d;
    logic [LEN_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OPM_DLY-1:0] dly_q, dly_d;
    logic [P_W-1:0]     result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic               ce_q, ce_d;
    logic               rstp_q, rstp_d;
    logic               b_sel_q, b_sel_d;
    logic [7:0]         opmode_q, opmode_d;
    logic               abort_rstp;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        bcas_d     = bcas_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        abort_rstp = 1'b0;

        // dly_q[k] holds rd_en from k+1 cycles ago
        dly_d[0] = rd_en_q;
        for (int i = 1; i < OPM_DLY; i++) begin
            dly_d[i] = dly_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    bcas_d = bus.b_cascade;
                    addr_d = '0;
                    if (bus.len != '0) begin
                        len_d   = bus.len;
                        state_d = S_CLEAR;
                    end else begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                addr_d  = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (addr_q == len_q - LEN_W'(1)) begin
                    cnt_d   = CNT_W'(DRAIN_N - 1);
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + LEN_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    result_d = bus.p_in;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef DSP_MAC_SEQ_ABORT_EN
        if (bus.abort && (state_q == S_CLEAR || state_q == S_ISSUE || state_q == S_DRAIN)) begin
            state_d    = S_IDLE;
            result_d   = result_q;
            dly_d      = '0;
            abort_rstp = 1'b1;
        end
`endif

        // outputs are registered, so decode them from the next state
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        rd_en_d  = (state_d == S_ISSUE);
        ce_d     = (state_d == S_CLEAR) || (state_d == S_ISSUE) || (state_d == S_DRAIN);
        rstp_d   = (state_d == S_CLEAR) || abort_rstp;
        b_sel_d  = busy_d ? bcas_d : 1'b0;
        opmode_d = busy_d ? (dly_d[OPM_DLY-1] ? 8'h09 : 8'h08) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            bcas_q   <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            dly_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            ce_q     <= 1'b0;
            rstp_q   <= 1'b0;
            b_sel_q  <= 1'b0;
            opmode_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            bcas_q   <= bcas_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            dly_q    <= dly_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            ce_q     <= ce_d;
            rstp_q   <= rstp_d;
            b_sel_q  <= b_sel_d;
            opmode_q <= opmode_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = addr_q;
    assign bus.opmode  = opmode_q;
    assign bus.ce      = ce_q;
    assign bus.rstp    = rstp_q;
    assign bus.b_sel   = b_sel_q;
    assign bus.result  = result_q;
endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed bench for dsp_mac_seq with a behavioural operand buffer + DSP48A1 slice model.
module tb_dsp_mac_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dsp_mac_seq_if #(.LEN_W(8), .P_W(48)) bus ();
    dsp_mac_seq dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // slice model: buffer read reg, A/B regs, combinational M, P reg
    logic [17:0] a_mem [0:255];
    logic [17:0] b_dir, bcin, a_buf, b_buf, a_reg, b_reg;
    logic [35:0] m;
    logic [47:0] p_reg;
    assign m        = a_reg * b_reg;
    assign bus.p_in = p_reg;

    always @(posedge clk) begin
        if (bus.rd_en) begin
            a_buf <= a_mem[bus.rd_addr];
            b_buf <= b_dir;
        end
        a_reg <= a_buf;
        b_reg <= bus.b_sel ? bcin : b_buf;
        if (rst || bus.rstp) p_reg <= '0;
        else if (bus.ce && bus.opmode == 8'h09) p_reg <= p_reg + {12'd0, m};
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tg, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tg, cyc, obs, exp);
        end
    endtask

    // full job with per-cycle expectations derived from the sequencing timeline
    task automatic job(input string tg, input int L, input logic bc, input logic [47:0] expres);
        logic [7:0] l8;
        logic e_rd, e_busy;
        l8 = L[7:0];
        bus.start = 1'b1; bus.len = l8; bus.b_cascade = bc;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= L + 6; c++) begin
            e_rd   = (c >= 2) && (c <= L + 1);
            e_busy = (c <= L + 5);
            chk({tg, "_busy"}, c, bus.busy, e_busy);
            chk({tg, "_done"}, c, bus.done, c == L + 5);
            chk({tg, "_rd_en"}, c, bus.rd_en, e_rd);
            if (e_rd) chk({tg, "_rd_addr"}, c, bus.rd_addr, c - 2);
            chk({tg, "_opmode"}, c, bus.opmode,
                (c >= 4 && c <= L + 3) ? 8'h09 : (e_busy ? 8'h08 : 8'h00));
            chk({tg, "_ce"}, c, bus.ce, c <= L + 4);
            chk({tg, "_rstp"}, c, bus.rstp, c == 1);
            chk({tg, "_b_sel"}, c, bus.b_sel, e_busy ? bc : 1'b0);
            if (c == L + 5) chk({tg, "_result"}, c, bus.result, expres);
            step();
        end
    endtask

    int dn;
    logic [7:0] max_addr;

    initial begin
        bus.start = 1'b0; bus.len = '0; bus.b_cascade = 1'b0;
`ifdef DSP_MAC_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        for (int i = 0; i < 256; i++) a_mem[i] = '0;
        b_dir = 18'd2; bcin = 18'd0;
        a_buf = '0; b_buf = '0; a_reg = '0; b_reg = '0;

        rst = 1'b1;
        repeat (3) step();
        chk("rst_busy", 0, bus.busy, 0);
        chk("rst_done", 0, bus.done, 0);
        chk("rst_rd_en", 0, bus.rd_en, 0);
        chk("rst_ce", 0, bus.ce, 0);
        chk("rst_rstp", 0, bus.rstp, 0);
        chk("rst_b_sel", 0, bus.b_sel, 0);
        chk("rst_rd_addr", 0, bus.rd_addr, 0);
        chk("rst_opmode", 0, bus.opmode, 8'h00);
        chk("rst_result", 0, bus.result, 0);
        rst = 1'b0;
        step();

        // 1: basic job, 1*2+2*2+3*2+4*2
        a_mem[0] = 18'd1; a_mem[1] = 18'd2; a_mem[2] = 18'd3; a_mem[3] = 18'd4;
        job("t1", 4, 1'b0, 48'd20);

`ifdef DSP_MAC_SEQ_ABORT_EN
        // 6: abort mid-issue keeps the previous result
        bus.start = 1'b1; bus.len = 8'd8; bus.b_cascade = 1'b0;
        step();
        bus.start = 1'b0;
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("t6_busy", 4, bus.busy, 0);
        chk("t6_rstp", 4, bus.rstp, 1);
        chk("t6_rd_en", 4, bus.rd_en, 0);
        chk("t6_ce", 4, bus.ce, 0);
        chk("t6_done", 4, bus.done, 0);
        chk("t6_result", 4, bus.result, 48'd20);
        step();
        chk("t6_rstp_once", 5, bus.rstp, 0);
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.done) dn++;
            step();
        end
        chk("t6_no_done", 0, dn, 0);
`endif

        // 2: zero-length job
        bus.start = 1'b1; bus.len = 8'd0;
        step();
        bus.start = 1'b0;
        chk("t2_done", 1, bus.done, 1);
        chk("t2_busy", 1, bus.busy, 1);
        chk("t2_result", 1, bus.result, 0);
        chk("t2_rd_en", 1, bus.rd_en, 0);
        chk("t2_rstp", 1, bus.rstp, 0);
        chk("t2_ce", 1, bus.ce, 0);
        step();
        chk("t2_done_end", 2, bus.done, 0);
        chk("t2_busy_end", 2, bus.busy, 0);

        // 5: cascade B source, 3*5+3*5
        b_dir = 18'd7; bcin = 18'd5;
        a_mem[0] = 18'd3; a_mem[1] = 18'd3;
        job("t5", 2, 1'b1, 48'd30);

        // 3: starts while busy and in DONE are ignored; result (3+3+3)*7
        bus.start = 1'b1; bus.len = 8'd3; bus.b_cascade = 1'b0;
        step();
        dn = 0; max_addr = '0;
        for (int c = 1; c <= 12; c++) begin
            bus.start = (c == 2 || c == 5 || c == 8);
            bus.len = 8'd7; bus.b_cascade = 1'b1;
            if (bus.rd_en && bus.rd_addr > max_addr) max_addr = bus.rd_addr;
            if (bus.done) dn++;
            chk("t3_b_sel", c, bus.b_sel, 0);
            if (c == 9) chk("t3_busy_after_done", c, bus.busy, 0);
            step();
        end
        bus.start = 1'b0; bus.b_cascade = 1'b0;
        chk("t3_max_addr", 0, max_addr, 2);
        chk("t3_done_cnt", 0, dn, 1);
        chk("t3_result", 0, bus.result, 48'd63);

        // 4: reset mid-job
        bus.start = 1'b1; bus.len = 8'd8;
        step();
        bus.start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_busy", 4, bus.busy, 0);
        chk("t4_rd_en", 4, bus.rd_en, 0);
        chk("t4_opmode", 4, bus.opmode, 8'h00);
        chk("t4_result", 4, bus.result, 0);
        dn = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus.done) dn++;
            step();
        end
        chk("t4_no_done", 0, dn, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
